// File: rtl/aes_pkg.sv
// Shared AES helpers: Rijndael ShiftRows offsets per block width,
// state byte indexing and the occupancy encoding of the skid buffer.
package aes_pkg;

  localparam int SHIFT_NB4_6 [0:3] = '{0, 1, 2, 3};
  localparam int SHIFT_NB8   [0:3] = '{0, 1, 3, 4};

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  function automatic int shift_off(input int nb, input int row);
    logic [1:0] r;
    r = row[1:0];
    if (nb == 8) begin
      return SHIFT_NB8[r];
    end else begin
      return SHIFT_NB4_6[r];
    end
  endfunction

  // Byte k of the state is row k%4, column k/4.
  function automatic int idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column
// Rijndael state; pure wiring plus one 2:1 mux per byte.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:32*NB-1] in_state,
  input  logic             inv,
  output logic [0:32*NB-1] out_state
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SR = shift_off(NB, r);
      localparam int K  = idx(r, c);
      localparam int KF = idx(r, (c + SR) % NB);
      localparam int KI = idx(r, (c - SR + NB) % NB);

      assign out_state[8*K +: 8] = inv ? in_state[8*KI +: 8] : in_state[8*KF +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered, valid/ready ShiftRows stage with a 2-entry skid buffer.
// The permutation is applied on accept, so both entries hold finished results.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:32*NB-1]  in_state,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_state,
  output logic              out_inv,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int SW = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [0:SW-1]      w_perm;
  cnt_e               r_cnt;
  cnt_e               w_cnt_nxt;
  logic               w_acc;
  logic               w_pop;
  logic               w_load_m_in;
  logic               w_load_m_s;
  logic               w_load_s;

  logic [0:SW-1]      r_m_state;
  logic               r_m_inv;
  logic [TAG_W-1:0]   r_m_tag;
  logic [0:SW-1]      r_s_state;
  logic               r_s_inv;
  logic [TAG_W-1:0]   r_s_tag;

  shift_rows_perm #(.NB(NB)) u_perm (
    .in_state  (in_state),
    .inv       (in_inv),
    .out_state (w_perm)
  );

  // in_ready depends only on the occupancy register, never on out_ready.
  assign in_ready  = (r_cnt != CNT_FULL);
  assign out_valid = (r_cnt != CNT_EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_state = r_m_state;
  assign out_inv   = r_m_inv;
  assign out_tag   = r_m_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CNT_EMPTY;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    case (r_cnt)
      CNT_EMPTY: begin
        if (w_acc) begin
          w_load_m_in = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = CNT_EMPTY;
        end
      end
      CNT_ONE: begin
        if (w_acc && !w_pop) begin
          w_load_s    = 1'b1;
          w_cnt_nxt   = CNT_FULL;
        end else if (w_acc && w_pop) begin
          w_load_m_in = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end else if (w_pop) begin
          w_cnt_nxt   = CNT_EMPTY;
        end else begin
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CNT_FULL: begin
        if (w_pop) begin
          w_load_m_s  = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = CNT_FULL;
        end
      end
      default: begin
        w_cnt_nxt = CNT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_state <= '0;
      r_m_inv   <= 1'b0;
      r_m_tag   <= '0;
    end else if (w_load_m_in) begin
      r_m_state <= w_perm;
      r_m_inv   <= in_inv;
      r_m_tag   <= in_tag;
    end else if (w_load_m_s) begin
      r_m_state <= r_s_state;
      r_m_inv   <= r_s_inv;
      r_m_tag   <= r_s_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_state <= '0;
      r_s_inv   <= 1'b0;
      r_s_tag   <= '0;
    end else if (w_load_s) begin
      r_s_state <= w_perm;
      r_s_inv   <= in_inv;
      r_s_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: vector table, scoreboard and
// hand-written stall/reset sequences; NB=6 and NB=8 instances for wider states.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [0:127] in_state, out_state;
  logic [3:0]   in_tag, out_tag;

  logic         v8_in, r8_in, inv8_in, v8_out, inv8_out;
  logic [0:255] st8_in, st8_out;
  logic [3:0]   tag8_in, tag8_out;

  logic         v6_in, r6_in, inv6_in, v6_out, inv6_out;
  logic [0:191] st6_in, st6_out;
  logic [3:0]   tag6_in, tag6_out;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_inv(out_inv), .out_tag(out_tag)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8_in), .in_ready(r8_in), .in_state(st8_in),
    .in_inv(inv8_in), .in_tag(tag8_in),
    .out_valid(v8_out), .out_ready(1'b1), .out_state(st8_out),
    .out_inv(inv8_out), .out_tag(tag8_out)
  );

  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(v6_in), .in_ready(r6_in), .in_state(st6_in),
    .in_inv(inv6_in), .in_tag(tag6_in),
    .out_valid(v6_out), .out_ready(1'b1), .out_state(st6_out),
    .out_inv(inv6_out), .out_tag(tag6_out)
  );

  typedef struct {
    logic [0:127] st;
    logic         inv;
    logic [3:0]   tag;
  } exp_t;

  typedef struct {
    logic [0:127] st;
    logic         inv;
    logic [3:0]   tag;
    logic [0:127] exp;
  } vec_t;

  exp_t sb[$];
  exp_t held;
  logic prev_stall = 1'b0;
  int   n_acc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {255'd0, act}, {255'd0, exp});
  endtask

  task automatic chk128(input string name, input logic [0:127] act, input logic [0:127] exp);
    chk(name, {128'd0, act}, {128'd0, exp});
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk(name, {252'd0, act}, {252'd0, exp});
  endtask

  // Reference permutation: the state occupies the leading 32*nb bits.
  function automatic logic [0:255] model(input logic [0:255] s, input int nb, input logic inv);
    logic [0:255] o;
    int sr;
    int src;
    o = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (nb == 8) sr = (r < 2) ? r : r + 1;
        else         sr = r;
        src = inv ? (c - sr + nb) % nb : (c + sr) % nb;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] m4(input logic [0:127] s, input logic inv);
    logic [0:255] t;
    t = model({s, 128'd0}, 4, inv);
    return t[0:127];
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: scoreboard bookkeeping at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk128("hold_state", out_state, held.st);
        chk1("hold_inv", out_inv, held.inv);
        chk4("hold_tag", out_tag, held.tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk1("sb_spurious_output", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk128("sb_state", out_state, e.st);
          chk1("sb_inv", out_inv, e.inv);
          chk4("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        e.st  = m4(in_state, in_inv);
        e.inv = in_inv;
        e.tag = in_tag;
        sb.push_back(e);
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      held.st  = out_state;
      held.inv = out_inv;
      held.tag = out_tag;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t         tbl [6];
  logic [0:127] orig;
  logic [0:127] fwd;
  logic [0:255] t8;
  logic [0:255] t6;
  logic [0:127] st_t6;
  int           cyc;

  initial begin
    tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'd2, 128'hd42711aee0bf98f1b8b45de51e415230};
    tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd3, 128'h00050a0f04090e03080d02070c01060b};
    tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd4, 128'h000d0a0704010e0b0805020f0c090603};
    tbl[4] = '{{128{1'b1}},                        1'b0, 4'd5, {128{1'b1}}};
    tbl[5] = '{128'd0,                              1'b1, 4'd6, 128'd0};

    rst = 1'b1;
    in_valid = 1'b0; in_state = '0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b0;
    v8_in = 1'b0; st8_in = '0; inv8_in = 1'b0; tag8_in = '0;
    v6_in = 1'b0; st6_in = '0; inv6_in = 1'b0; tag6_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk128("rst_out_state", out_state, 128'd0);
    chk4("rst_out_tag", out_tag, 4'd0);
    chk1("rst_out_inv", out_inv, 1'b0);

    // Vector table, back to back, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_state = tbl[i].st; in_inv = tbl[i].inv; in_tag = tbl[i].tag;
      tick();
      chk1($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk128($sformatf("tbl%0d_state", i), out_state, tbl[i].exp);
      chk1($sformatf("tbl%0d_inv", i), out_inv, tbl[i].inv);
      chk4($sformatf("tbl%0d_tag", i), out_tag, tbl[i].tag);
    end
    in_valid = 1'b0;
    tick();
    chk1("tbl_drain_valid", out_valid, 1'b0);

    // Forward then inverse returns the original
    for (int i = 0; i < 1000; i++) begin
      orig = rnd128();
      in_valid = 1'b1; in_state = orig; in_inv = 1'b0; in_tag = 4'(i);
      tick();
      fwd = out_state;
      in_state = fwd; in_inv = 1'b1;
      tick();
      chk128("roundtrip", out_state, orig);
    end
    in_valid = 1'b0;
    tick();

    // NB=8: bytes 00..1f forward, then inverse against the model
    for (int k = 0; k < 32; k++) st8_in[8*k +: 8] = k[7:0];
    v8_in = 1'b1; inv8_in = 1'b0; tag8_in = 4'd7;
    chk1("nb8_in_ready", r8_in, 1'b1);
    tick();
    chk1("nb8_valid", v8_out, 1'b1);
    chk(("nb8_word0"), {224'd0, st8_out[0:31]}, {224'd0, 32'h00050e13});
    chk(("nb8_word7"), {224'd0, st8_out[224:255]}, {224'd0, 32'h1c010a0f});
    chk("nb8_fwd_model", st8_out, model(st8_in, 8, 1'b0));
    chk4("nb8_tag", tag8_out, 4'd7);
    t8 = {rnd128(), rnd128()};
    st8_in = t8; inv8_in = 1'b1;
    tick();
    chk("nb8_inv_model", st8_out, model(t8, 8, 1'b1));
    chk1("nb8_inv_flag", inv8_out, 1'b1);
    v8_in = 1'b0;

    // NB=6 sweep against the model
    for (int i = 0; i < 24; i++) begin
      st_t6 = rnd128();
      st6_in = {st_t6, $urandom(), $urandom()};
      inv6_in = 1'(i % 2); tag6_in = 4'(i); v6_in = 1'b1;
      tick();
      t6 = model({st6_in, 64'd0}, 6, inv6_in);
      chk("nb6_model", {64'd0, st6_out}, {64'd0, t6[0:191]});
      chk1("nb6_inv", inv6_out, inv6_in);
      chk4("nb6_tag", tag6_out, tag6_in);
      chk1("nb6_valid", v6_out & r6_in, 1'b1);
    end
    v6_in = 1'b0;
    tick();

    // Stall: tags 1,2 fill the buffer, tag 3 waits, then drain without a bubble
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_state = rnd128(); in_tag = 4'd1;
    chk1("t4_ready_a", in_ready, 1'b1);
    tick();
    in_state = rnd128(); in_tag = 4'd2;
    chk1("t4_ready_b", in_ready, 1'b1);
    tick();
    in_state = rnd128(); in_tag = 4'd3;
    chk1("t4_full", in_ready, 1'b0);
    tick();
    chk1("t4_still_full", in_ready, 1'b0);
    chk4("t4_head_tag", out_tag, 4'd1);
    out_ready = 1'b1;
    tick();
    chk1("t4_v2", out_valid, 1'b1);
    chk4("t4_tag2", out_tag, 4'd2);
    tick();
    chk1("t4_v3", out_valid, 1'b1);
    chk4("t4_tag3", out_tag, 4'd3);
    in_valid = 1'b0;
    tick();
    chk1("t4_empty", out_valid, 1'b0);

    // Random handshakes; scoreboard checks order and stall stability
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid) begin
        in_state = rnd128(); in_inv = 1'($urandom_range(0, 1)); in_tag = 4'($urandom_range(0, 15));
      end
      tick();
      cyc++;
    end
    chk1("t5_accept_count", n_acc >= 10000, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_sb_empty", 256'(sb.size()), 256'd0);
    chk1("t5_drained", out_valid, 1'b0);

    // Reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b1; in_state = rnd128(); in_tag = 4'd4;
    tick();
    in_state = rnd128(); in_tag = 4'd5;
    tick();
    chk1("t6_full", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk1("t6_valid", out_valid, 1'b0);
    chk1("t6_ready", in_ready, 1'b1);
    chk128("t6_state", out_state, 128'd0);
    chk4("t6_tag", out_tag, 4'd0);
    chk1("t6_inv", out_inv, 1'b0);
    out_ready = 1'b1;
    tick();
    chk1("t6_no_emit", out_valid, 1'b0);
    orig = rnd128();
    in_valid = 1'b1; in_state = orig; in_inv = 1'b0; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    chk1("t6_new_valid", out_valid, 1'b1);
    chk128("t6_new_state", out_state, m4(orig, 1'b0));
    chk4("t6_new_tag", out_tag, 4'd9);
    tick();
    chk1("t6_new_popped", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
